// File: rtl/nes_clk_enables.sv
// nes_clk_enables: divides the master clock into CPU/PPU enables and M2, sequences the
// domain resets, and freezes the dividers at CPU-cycle boundaries for debug halt/step.
module nes_clk_enables #(
  parameter int RST_CYCLES = 127,
  parameter int PPU_LEAD   = 31
) (
  input  logic       clk_master,
  input  logic       rst_master,
  input  logic [1:0] region,
  input  logic       halt,
  input  logic       step,
  input  logic       soft_rst,
  output logic       ppu_ce,
  output logic       cpu_ce,
  output logic       m2,
  output logic       rst_ppu,
  output logic       rst_cpu,
  output logic       halted,
  output logic [1:0] region_active,
  output logic [3:0] cpu_phase
);
  localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES);
  localparam logic [15:0] LEAD     = 16'(PPU_LEAD);
  typedef enum logic [1:0] {S_RUN, S_FROZEN, S_STEP} state_t;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cpu_cnt, w_cpu_nxt, w_cpu_last, w_m2_low;
  logic [2:0]  r_ppu_cnt, w_ppu_nxt, w_ppu_last;
  logic [15:0] r_rst_ctr;
  logic [1:0]  r_region, w_region_in;
  logic        r_m2, r_rst_ppu, r_rst_cpu, w_frozen, w_cpu_ce, w_ppu_ce;
  always_comb begin
    w_cpu_last  = r_region == 2'd1 ? 4'd15 : r_region == 2'd2 ? 4'd14 : 4'd11;
    w_ppu_last  = r_region == 2'd0 ? 3'd3 : 3'd4;
    w_m2_low    = r_region == 2'd0 ? 4'd5 : 4'd6;
    w_region_in = region == 2'd3 ? 2'd0 : region;
    w_frozen    = r_state == S_FROZEN;
    w_cpu_ce    = !w_frozen && r_cpu_cnt == w_cpu_last;
    w_ppu_ce    = !w_frozen && r_ppu_cnt == w_ppu_last;
    w_state_nxt = w_frozen ? (!halt ? S_RUN : step ? S_STEP : S_FROZEN)
                : (w_cpu_ce && (halt || r_state == S_STEP)) ? S_FROZEN : r_state;
    w_cpu_nxt   = w_frozen ? r_cpu_cnt : w_cpu_ce ? 4'd0 : r_cpu_cnt + 4'd1;
    // PPU phase restarts whenever a new CPU period begins on a freeze or a region change
    w_ppu_nxt   = w_frozen ? r_ppu_cnt
                : (w_ppu_ce || (w_cpu_ce && (w_state_nxt == S_FROZEN || w_region_in != r_region))) ? 3'd0
                : r_ppu_cnt + 3'd1;
  end
  always_ff @(posedge clk_master or posedge rst_master)
    if (rst_master) begin
      r_state   <= S_RUN;
      r_cpu_cnt <= 4'd0;
      r_ppu_cnt <= 3'd0;
      r_rst_ctr <= RST_LOAD;
      r_region  <= 2'd0;
      r_m2      <= 1'b0;
      r_rst_ppu <= 1'b1;
      r_rst_cpu <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_cnt <= w_cpu_nxt;
      r_ppu_cnt <= w_ppu_nxt;
      r_rst_ctr <= soft_rst ? RST_LOAD : r_rst_ctr == 16'd0 ? 16'd0 : r_rst_ctr - 16'd1;
      r_m2      <= w_cpu_nxt >= w_m2_low;
      r_rst_ppu <= r_rst_ppu && r_rst_ctr > LEAD;
      r_rst_cpu <= soft_rst || (r_rst_cpu && !(w_cpu_ce && r_rst_ctr == 16'd0));
      if (w_cpu_ce) r_region <= w_region_in;
    end
  assign ppu_ce        = w_ppu_ce;
  assign cpu_ce        = w_cpu_ce;
  assign m2            = r_m2;
  assign rst_ppu       = r_rst_ppu;
  assign rst_cpu       = r_rst_cpu;
  assign halted        = w_frozen;
  assign region_active = r_region;
  assign cpu_phase     = r_cpu_cnt;
endmodule

// File: tb/tb_nes_clk_enables.sv
// tb_nes_clk_enables: directed and random stimulus against a cycle-level behavioural model.
module tb_nes_clk_enables;
  logic       clk_master = 1'b0, rst_master = 1'b1, halt = 1'b0, step = 1'b0, soft_rst = 1'b0;
  logic [1:0] region = 2'd0;
  logic       ppu_ce, cpu_ce, m2, rst_ppu, rst_cpu, halted;
  logic [1:0] region_active;
  logic [3:0] cpu_phase;
  int vectors = 0, miscompares = 0;
  int m_ph, m_pph, m_ra, m_mode, m_ctr;
  bit m_rppu, m_rcpu, prev_rcpu;
  int edges, first_cpu, first_ppu, ppu_fall, cpu_fall, cpu_rise, last_cpu, cpu_gap, last_ppu, ppu_gap;
  int n_cpu, n_ppu, n_halt;

  nes_clk_enables dut (
    .clk_master(clk_master), .rst_master(rst_master), .region(region), .halt(halt),
    .step(step), .soft_rst(soft_rst), .ppu_ce(ppu_ce), .cpu_ce(cpu_ce), .m2(m2),
    .rst_ppu(rst_ppu), .rst_cpu(rst_cpu), .halted(halted), .region_active(region_active),
    .cpu_phase(cpu_phase)
  );

  always #5 clk_master = ~clk_master;

  initial begin
    #1000000;
    $error("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  // Region tables: 0 NTSC, 1 PAL, 2 Dendy
  function automatic int cdiv(int r); return r == 1 ? 16 : r == 2 ? 15 : 12; endfunction
  function automatic int pdiv(int r); return r == 0 ? 4 : 5; endfunction
  function automatic int m2low(int r); return r == 0 ? 5 : 6; endfunction

  function automatic void model_reset();
    m_ph = 0; m_pph = 0; m_ra = 0; m_mode = 0; m_ctr = 127; m_rppu = 1; m_rcpu = 1;
  endfunction

  function automatic void trk_reset();
    edges = 0; first_cpu = -1; first_ppu = -1; ppu_fall = -1; last_cpu = 0; last_ppu = 0;
  endfunction

  // mode: 0 running, 1 halted, 2 stepping
  function automatic void model_edge(bit h, bit s, bit sr, logic [1:0] rg);
    int d, p, nr;
    bit run, cce, frz;
    d = cdiv(m_ra); p = pdiv(m_ra); nr = rg == 2'd3 ? 0 : int'(rg);
    run = m_mode != 1;
    cce = run && m_ph == d - 1;
    m_rppu = m_rppu && m_ctr > 31;
    if (sr) m_rcpu = 1; else if (cce && m_ctr == 0) m_rcpu = 0;
    m_ctr = sr ? 127 : (m_ctr > 0 ? m_ctr - 1 : 0);
    if (!run) begin
      if (!h) m_mode = 0; else if (s) m_mode = 2;
    end else if (cce) begin
      frz = h || m_mode == 2;
      m_pph = (frz || nr != m_ra) ? 0 : (m_pph + 1) % p;
      m_ph = 0; m_ra = nr;
      if (frz) m_mode = 1;
    end else begin
      m_ph = m_ph + 1; m_pph = (m_pph + 1) % p;
    end
  endfunction

  function automatic logic [11:0] expected();
    bit frz;
    frz = m_mode == 1;
    return {!frz && m_pph == pdiv(m_ra) - 1, !frz && m_ph == cdiv(m_ra) - 1, m_ph >= m2low(m_ra),
            m_rppu, m_rcpu, frz, 2'(m_ra), 4'(m_ph)};
  endfunction

  task automatic check(string tag);
    logic [11:0] obs, exp;
    obs = {ppu_ce, cpu_ce, m2, rst_ppu, rst_cpu, halted, region_active, cpu_phase};
    exp = expected();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s edge %0d: observed {ppu,cpu,m2,rp,rc,hlt,reg,ph}=%b expected %b", tag, edges, obs, exp);
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(bit r, bit h, bit s, bit sr, logic [1:0] rg);
    @(negedge clk_master);
    check("cycle");
    if (cpu_ce) begin
      if (first_cpu < 0) first_cpu = edges;
      cpu_gap = edges - last_cpu; last_cpu = edges; n_cpu++;
    end
    if (ppu_ce) begin
      if (first_ppu < 0) first_ppu = edges;
      ppu_gap = edges - last_ppu; last_ppu = edges; n_ppu++;
    end
    if (!rst_ppu && ppu_fall < 0) ppu_fall = edges;
    if (prev_rcpu && !rst_cpu) cpu_fall = edges;
    if (!prev_rcpu && rst_cpu) cpu_rise = edges;
    prev_rcpu = rst_cpu;
    if (halted) n_halt++;
    rst_master = r; halt = h; step = s; soft_rst = sr; region = rg;
    if (r) begin
      model_reset(); trk_reset();
    end else begin
      model_edge(h, s, sr, rg); edges++;
    end
  endtask

  initial begin
    int g;
    bit h;
    logic [1:0] rg;
    model_reset(); trk_reset(); prev_rcpu = 1;
    repeat (3) tick(1, 0, 0, 0, 2'd0);
    while (edges < 299) tick(0, 0, 0, 0, 2'd0);
    chk("first_cpu_ce", first_cpu, 11);
    chk("first_ppu_ce", first_ppu, 3);
    chk("rst_ppu_fall", ppu_fall, 97);
    chk("rst_cpu_fall", cpu_fall, 132);
    tick(0, 0, 0, 1, 2'd0);
    repeat (140) tick(0, 0, 0, 0, 2'd0);
    chk("soft_rst_rise", cpu_rise, 300);
    chk("soft_rst_fall", cpu_fall, 432);
    chk("soft_rst_ppu_held", rst_ppu, 0);
    g = 0;
    while (cpu_phase != 4'd5 && g < 40) begin tick(0, 0, 0, 0, 2'd0); g++; end
    chk("find_phase5", int'(g < 40), 1);
    repeat (70) tick(0, 0, 0, 0, 2'd1);
    chk("pal_cpu_gap", cpu_gap, 16);
    chk("pal_ppu_gap", ppu_gap, 5);
    chk("pal_region", region_active, 1);
    repeat (40) tick(0, 0, 0, 0, 2'd0);
    chk("ntsc_cpu_gap", cpu_gap, 12);
    g = 0;
    while (cpu_phase != 4'd4 && g < 40) begin tick(0, 0, 0, 0, 2'd0); g++; end
    chk("find_phase4", int'(g < 40), 1);
    n_cpu = 0; n_ppu = 0;
    repeat (20) tick(0, 1, 0, 0, 2'd0);
    chk("halt_last_cpu_ce", n_cpu, 1);
    chk("halt_last_ppu_ce", n_ppu, 2);
    n_cpu = 0; n_ppu = 0; n_halt = 0;
    repeat (100) tick(0, 1, 0, 0, 2'd0);
    chk("frozen_cpu_ce", n_cpu, 0);
    chk("frozen_ppu_ce", n_ppu, 0);
    chk("frozen_halted", n_halt, 100);
    n_cpu = 0; n_ppu = 0;
    tick(0, 1, 1, 0, 2'd0);
    repeat (5) tick(0, 1, 0, 0, 2'd0);
    tick(0, 1, 1, 0, 2'd0);
    repeat (25) tick(0, 1, 0, 0, 2'd0);
    chk("step_cpu_ce", n_cpu, 1);
    chk("step_ppu_ce", n_ppu, 3);
    chk("step_rehalted", halted, 1);
    h = 0; rg = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) h = !h;
      if ($urandom_range(99) == 0) rg = 2'($urandom_range(3));
      tick(0, h, $urandom_range(7) == 0, $urandom_range(199) == 0, rg);
    end
    g = 0;
    while (!halted && g < 40) begin tick(0, 1, 0, 0, 2'd0); g++; end
    chk("halt_before_async", halted, 1);
    tick(0, 1, 1, 0, 2'd3);
    repeat (4) tick(0, 1, 0, 0, 2'd3);
    chk("mid_step", halted, 0);
    #2 rst_master = 1'b1;
    #1 model_reset(); trk_reset();
    check("async_reset");
    chk("async_phase", cpu_phase, 0);
    repeat (2) tick(1, 0, 0, 0, 2'd3);
    while (edges < 200) tick(0, 0, 0, 0, 2'd3);
    chk("post_async_first_cpu", first_cpu, 11);
    chk("post_async_gap", cpu_gap, 12);
    chk("post_async_region", region_active, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nes_clk_enables.md
NES_CLK_ENABLES -- requirements
Module: nes_clk_enables

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 127: master cycles from reset release until rst_ctr reaches 0; range 32..65535.
REQ-002 SHALL have parameter PPU_LEAD, default 31: rst_ppu releases when rst_ctr falls to PPU_LEAD or below; PPU_LEAD < RST_CYCLES.
REQ-003 SHALL have port clk_master, input, 1 bit: the only clock.
REQ-004 SHALL have port rst_master, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port region, input, 2 bits: 0 = NTSC, 1 = PAL, 2 = Dendy, 3 = treated as NTSC.
REQ-006 SHALL have port halt, input, 1 bit: debug halt request, sampled each cycle.
REQ-007 SHALL have port step, input, 1 bit: single-CPU-cycle request, valid only while halted.
REQ-008 SHALL have port soft_rst, input, 1 bit: synchronous request to restart the CPU reset sequence.
REQ-009 SHALL have port ppu_ce, output, 1 bit: PPU clock enable, one master cycle wide.
REQ-010 SHALL have port cpu_ce, output, 1 bit: CPU clock enable, one master cycle wide.
REQ-011 SHALL have port m2, output, 1 bit: cartridge M2 phase.
REQ-012 SHALL have ports rst_ppu and rst_cpu, outputs, 1 bit each: active-high domain resets.
REQ-013 SHALL have port halted, output, 1 bit: counters frozen.
REQ-014 SHALL have ports region_active (output, 2 bits) and cpu_phase (output, 4 bits): applied region, and current cpu_cnt.

Function
REQ-015 SHALL use divisors (CPU_DIV, PPU_DIV, M2_LOW): NTSC (12, 4, 5); PAL (16, 5, 6); Dendy (15, 5, 6).
REQ-016 SHALL increment cpu_cnt each non-frozen cycle, wrapping from CPU_DIV-1 to 0.
REQ-017 SHALL increment ppu_cnt each non-frozen cycle, wrapping from PPU_DIV-1 to 0.
REQ-018 SHALL assert cpu_ce exactly in cycles where cpu_cnt == CPU_DIV-1 and the counters are not frozen.
REQ-019 SHALL assert ppu_ce exactly in cycles where ppu_cnt == PPU_DIV-1 and the counters are not frozen.
REQ-020 SHALL assert m2 in cycles where cpu_cnt >= M2_LOW; m2 comes from a flop and is glitch-free.
REQ-021 SHALL sample region each cycle and load region_active only in a cpu_ce cycle; both counters are 0 on the following cycle, with no partial period.
REQ-022 SHALL load rst_ctr with RST_CYCLES on reset, then decrement it each cycle and saturate at 0, whether or not halted.
REQ-023 SHALL set rst_ppu on each edge to the registered value (rst_ctr > PPU_LEAD); soft_rst does not affect rst_ppu.
REQ-024 SHALL clear rst_cpu on the edge that samples cpu_ce = 1 with rst_ctr == 0; rst_cpu never deasserts mid-CPU-cycle.
REQ-025 SHALL, on soft_rst = 1: reload rst_ctr with RST_CYCLES and set rst_cpu on the next edge; counters continue.
REQ-026 SHALL, when halt = 1 while running: freeze at the next wrap, i.e. the cpu_ce cycle completes, both counters hold 0, and halted = 1; no ce pulses while frozen.
REQ-027 SHALL, on step = 1 while halted: run exactly CPU_DIV master cycles, giving one cpu_ce plus matching ppu_ce pulses, then re-freeze at 0.
REQ-028 SHALL ignore step while running or mid-step.
REQ-029 SHALL, on halt = 0 while halted: resume counting on the next cycle.
REQ-030 SHALL apply a region change pending at a halt point when the first cpu_ce after resume or step occurs.
REQ-031 SHALL keep rst_cpu asserted while halted with rst_ctr == 0; it releases at the first stepped or resumed cpu_ce.
REQ-032 SHALL take halt over step when both are asserted in the same cycle while running.
REQ-033 SHALL sample soft_rst during a step and complete the step.

Reset
REQ-034 SHALL, while rst_master = 1: hold cpu_cnt = ppu_cnt = 0, ppu_ce = cpu_ce = m2 = 0, rst_ppu = rst_cpu = 1, halted = 0, region_active = 0, cpu_phase = 0, rst_ctr = RST_CYCLES.
REQ-035 SHALL, on rst_master assertion mid-operation (including mid-step or halted): force all REQ-034 values immediately; region_active reloads only at the first cpu_ce after release.

Verification
REQ-036 SHALL pass NTSC reset release with defaults (edge k = k-th edge after release): cpu_ce after edges 11, 23, ...; ppu_ce after edges 3, 7, 11, ...; m2 high for cpu_phase 5..11; rst_ppu falls at edge 97; rst_cpu falls at edge 132.
REQ-037 SHALL pass region switch NTSC to PAL mid-period: no change until cpu_ce; then 16-cycle cpu_ce spacing, ppu_ce spacing 5, region_active = 1.
REQ-038 SHALL pass halt asserted at cpu_phase 4: cpu_ce still occurs at phase 11, then halted = 1 with no ce for 100 cycles.
REQ-039 SHALL pass a single step pulse while halted: exactly one cpu_ce and three ppu_ce (NTSC), then halted again; a second step mid-step is ignored.
REQ-040 SHALL pass soft_rst at edge 300: rst_cpu = 1 next edge; rst_ppu stays 0; rst_cpu clears on the first cpu_ce at or after 128 edges later.
REQ-041 SHALL pass async rst_master pulse mid-step with region = 3: outputs reset without waiting for a clock edge; NTSC timing resumes and region_active = 0.
